cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter for the out-of-order core.
- Collects completed results from NUM_SRC producers (ALUs, load buffer, address unit). Each producer has its own small FIFO.
- Once per cycle, grants one queued result onto the single registered CDB broadcast. The reservation station, register rename ready table and reorder buffer consume that broadcast.
- Replaces the fixed single-ALU common_data_bus: adds N sources, per-source queueing, round-robin fairness, and flush.

Parameters:
- NUM_SRC, 4, number of producer channels (2..8).
- DATA_WIDTH, 32, result data width.
- TAG_WIDTH, 6, physical register tag width.
- ROB_IDX_WIDTH, 4, reorder buffer index width.
- QUEUE_DEPTH, 2, entries per source FIFO (power of 2, >=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source FIFO can accept.
- src_tag  in  NUM_SRC*TAG_WIDTH  packed tags; source i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- src_data  in  NUM_SRC*DATA_WIDTH  packed data, same packing.
- src_rob_idx  in  NUM_SRC*ROB_IDX_WIDTH  packed ROB indices, same packing.
- flush  in  1  mispredict flush; drops all queued and pending results.
- rob_head  in  ROB_IDX_WIDTH  ROB head index; used only with CDB_OLDEST_FIRST_EN.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_WIDTH  broadcast physical tag.
- cdb_data  out  DATA_WIDTH  broadcast data.
- cdb_rob_idx  out  ROB_IDX_WIDTH  broadcast ROB index.
- cdb_grant  out  NUM_SRC  one-hot source of the current broadcast; all zero when cdb_valid=0.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - all FIFOs empty.
  - cdb_valid=0; cdb_tag, cdb_data, cdb_rob_idx, cdb_grant all 0.
  - round-robin pointer = 0.
  - src_ready=0 while rst is high.
- src_ready[i] = !rst && (count_i < QUEUE_DEPTH).
  - Depends only on the registered count, never on a same-cycle pop.
  - A full queue accepts nothing, even in the cycle it is popped.
- Push: when src_valid[i] && src_ready[i] at a rising edge, {tag, data, rob_idx} is written at the FIFO tail.
  - Asserting src_valid while src_ready=0 is a protocol error. The input is ignored and no state changes.
- FIFO pointers: log2(QUEUE_DEPTH)-bit wrap-around pointers plus a count of width log2(QUEUE_DEPTH)+1.
  - A simultaneous push and pop on one FIFO leaves count unchanged.
- Arbitration: combinational over the non-empty FIFOs.
  - Round-robin: search starts at the pointer and wraps modulo NUM_SRC.
  - On a grant, the pointer becomes (granted+1) mod NUM_SRC. With no grant, the pointer holds.
  - The granted FIFO head pops at the same edge that the output register loads.
- Output register:
  - Loads the granted head and a one-hot cdb_grant every cycle.
  - cdb_valid=1 iff a grant occurred. With no grant: cdb_valid=0, cdb_grant=0, and data, tag and rob_idx hold their previous values.
- Latency: a push at edge E broadcasts at the earliest after edge E+1 (2 cycles). There is no FIFO bypass.
- Throughput: 1 broadcast per cycle in aggregate.
- Flush (priority below rst, above all else):
  - At the edge: all FIFOs emptied, cdb_valid=0, cdb_grant=0.
  - Pushes in that cycle are dropped. The round-robin pointer is preserved.
- Reset mid-operation: everything is discarded and restarts from the reset values.

Optional Feature:
- Macro: CDB_OLDEST_FIRST_EN.
- Defined: arbitration picks the non-empty head with the smallest age, where age = (rob_idx - rob_head) mod 2^ROB_IDX_WIDTH.
  - Ties go to the lowest source index.
  - The round-robin pointer is not used.
- Undefined: pure round-robin as described above; rob_head is ignored.

Test Plan:
- Reset released, source 1 pushes tag=5, data=0xDEADBEEF, rob=3 at edge 0 -> cdb_valid=1 after edge 1 with the same values; cdb_grant=4'b0010; cdb_valid=0 the following cycle.
- All 4 sources push in the same cycle, pointer=0 -> broadcasts from sources 0,1,2,3 on 4 consecutive cycles, then cdb_valid=0.
- Source 2 pushes 3 times back-to-back with no pops possible (QUEUE_DEPTH=2, other sources saturating) -> src_ready[2]=0 after 2 accepts; the third result is taken only after one entry drains.
- Sources 0 and 3 kept continuously non-empty -> grants alternate 0,3,0,3; neither starves.
- 4 queued entries, flush asserted with a simultaneous push -> next cycle cdb_valid=0, all src_ready=1, and no queued or pushed result is ever broadcast.
- With CDB_OLDEST_FIRST_EN, rob_head=14, heads rob_idx {src0=2, src1=15} -> src1 granted first (age 1 versus age 4).

Source files
------------

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Common-data-bus arbiter for the out-of-order core. Each of NUM_SRC result
// producers (ALUs, load buffer, address unit) writes completed results into
// its own small FIFO. Once per cycle one non-empty FIFO head is granted and
// loaded into the registered CDB broadcast consumed by the reservation
// station, the rename ready table and the reorder buffer.
//
// Optional feature macro: CDB_OLDEST_FIRST_EN
//   undefined : round-robin arbitration, rob_head ignored
//   defined   : oldest-first arbitration by (rob_idx - rob_head), ties to the
//               lowest source index, round-robin pointer not consulted
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   src_valid    per-source result valid
//   src_ready    per-source FIFO can accept (0 while rst is high)
//   src_tag      packed tags, source i at [i*TAG_WIDTH +: TAG_WIDTH]
//   src_data     packed data, same packing
//   src_rob_idx  packed ROB indices, same packing
//   flush        mispredict flush, drops everything queued or arriving
//   rob_head     ROB head index (oldest-first mode only)
//   cdb_valid    broadcast valid
//   cdb_tag      broadcast physical tag
//   cdb_data     broadcast data
//   cdb_rob_idx  broadcast ROB index
//   cdb_grant    one-hot source of the broadcast, zero when cdb_valid=0
// ---------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_SRC       = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int TAG_WIDTH     = 6,
   parameter int ROB_IDX_WIDTH = 4,
   parameter int QUEUE_DEPTH   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_SRC-1:0]                src_valid,
   output logic [NUM_SRC-1:0]                src_ready,
   input  logic [NUM_SRC*TAG_WIDTH-1:0]      src_tag,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]     src_data,
   input  logic [NUM_SRC*ROB_IDX_WIDTH-1:0]  src_rob_idx,
   input  logic                              flush,
   input  logic [ROB_IDX_WIDTH-1:0]          rob_head,
   output logic                              cdb_valid,
   output logic [TAG_WIDTH-1:0]              cdb_tag,
   output logic [DATA_WIDTH-1:0]             cdb_data,
   output logic [ROB_IDX_WIDTH-1:0]          cdb_rob_idx,
   output logic [NUM_SRC-1:0]                cdb_grant
);

   // A depth-1 FIFO still gets a 1-bit pointer so the vectors stay legal;
   // the wrap logic keeps it at zero.
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
   localparam int SRC_W = $clog2(NUM_SRC);
   localparam int SUM_W = SRC_W + 1;

   logic [TAG_WIDTH-1:0]     q_tag  [NUM_SRC][QUEUE_DEPTH];
   logic [DATA_WIDTH-1:0]    q_data [NUM_SRC][QUEUE_DEPTH];
   logic [ROB_IDX_WIDTH-1:0] q_rob  [NUM_SRC][QUEUE_DEPTH];

   logic [PTR_W-1:0] wr_ptr [NUM_SRC];
   logic [PTR_W-1:0] rd_ptr [NUM_SRC];
   logic [CNT_W-1:0] count  [NUM_SRC];

   logic [TAG_WIDTH-1:0]     head_tag  [NUM_SRC];
   logic [DATA_WIDTH-1:0]    head_data [NUM_SRC];
   logic [ROB_IDX_WIDTH-1:0] head_rob  [NUM_SRC];
   logic [NUM_SRC-1:0]       not_empty;
   logic [NUM_SRC-1:0]       push;
   logic [NUM_SRC-1:0]       pop;

   logic             grant_valid;
   logic [SRC_W-1:0] grant_idx;
   logic [SRC_W-1:0] rr_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(QUEUE_DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Ready comes only from the registered occupancy, so a full queue refuses
   // a push even in the cycle its head is being popped.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ready[i] = !rst && (count[i] < CNT_W'(QUEUE_DEPTH));
         not_empty[i] = (count[i] != '0);
         head_tag[i]  = q_tag[i][rd_ptr[i]];
         head_data[i] = q_data[i][rd_ptr[i]];
         head_rob[i]  = q_rob[i][rd_ptr[i]];
      end
   end

`ifdef CDB_OLDEST_FIRST_EN
   logic [ROB_IDX_WIDTH-1:0] cand_age;
   logic [ROB_IDX_WIDTH-1:0] best_age;

   // Oldest-first: age is the modular distance from the ROB head. The strict
   // less-than keeps the lowest source index on a tie.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand_age    = '0;
      best_age    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand_age = head_rob[i] - rob_head;
         if (not_empty[i] && (!grant_valid || (cand_age < best_age))) begin
            grant_valid = 1'b1;
            grant_idx   = SRC_W'(i);
            best_age    = cand_age;
         end
      end
   end
`else
   logic [SUM_W-1:0] rr_sum;
   logic             unused_rob_head;

   assign unused_rob_head = ^rob_head;

   // Round-robin: walk the sources starting at rr_ptr, wrapping modulo
   // NUM_SRC (which need not be a power of two), and take the first
   // non-empty one.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      rr_sum      = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         rr_sum = {1'b0, rr_ptr} + SUM_W'(k);
         if (rr_sum >= SUM_W'(NUM_SRC)) begin
            rr_sum = rr_sum - SUM_W'(NUM_SRC);
         end
         if (!grant_valid && not_empty[rr_sum[SRC_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = rr_sum[SRC_W-1:0];
         end
      end
   end
`endif

   // Flush kills both the arriving pushes and the pop of this cycle, so
   // nothing that was in flight can reach the bus afterwards.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         push[i] = src_valid[i] && src_ready[i] && !flush;
         pop[i]  = grant_valid && (grant_idx == SRC_W'(i)) && !flush;
      end
   end

   // FIFO pointers and occupancy; a push and pop together leave count alone.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (rst || flush) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end else begin
            if (push[i]) begin
               wr_ptr[i] <= ptr_inc(wr_ptr[i]);
            end
            if (pop[i]) begin
               rd_ptr[i] <= ptr_inc(rd_ptr[i]);
            end
            if (push[i] && !pop[i]) begin
               count[i] <= count[i] + 1'b1;
            end else if (pop[i] && !push[i]) begin
               count[i] <= count[i] - 1'b1;
            end
         end
      end
   end

   // Entry storage needs no reset: occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (push[i]) begin
            q_tag[i][wr_ptr[i]]  <= src_tag[i*TAG_WIDTH +: TAG_WIDTH];
            q_data[i][wr_ptr[i]] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
            q_rob[i][wr_ptr[i]]  <= src_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
         end
      end
   end

   // Broadcast register and round-robin pointer. With no grant the payload
   // holds its last value; only valid and grant drop. Flush leaves the
   // pointer where it was so fairness carries across the mispredict.
   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid   <= 1'b0;
         cdb_tag     <= '0;
         cdb_data    <= '0;
         cdb_rob_idx <= '0;
         cdb_grant   <= '0;
         rr_ptr      <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
         cdb_grant <= '0;
      end else if (grant_valid) begin
         cdb_valid   <= 1'b1;
         cdb_tag     <= head_tag[grant_idx];
         cdb_data    <= head_data[grant_idx];
         cdb_rob_idx <= head_rob[grant_idx];
         cdb_grant   <= NUM_SRC'(1) << grant_idx;
         rr_ptr      <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
         cdb_valid <= 1'b0;
         cdb_grant <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter (default parameters). Stimulus pushes the
// hand-ordered broadcasts it expects into a queue; a negedge monitor pops and
// compares every time the DUT presents cdb_valid, and flags any broadcast
// that arrives with nothing expected.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  src_valid;
   logic [3:0]  src_ready;
   logic [23:0] src_tag;
   logic [127:0] src_data;
   logic [15:0] src_rob_idx;
   logic        flush;
   logic [3:0]  rob_head;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [3:0]  cdb_rob_idx;
   logic [3:0]  cdb_grant;

   typedef struct packed {
      logic [5:0]  tag;
      logic [31:0] data;
      logic [3:0]  rob;
      logic [3:0]  grant;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   passes = 0;
   int   waited;

   cdb_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .src_tag     (src_tag),
      .src_data    (src_data),
      .src_rob_idx (src_rob_idx),
      .flush       (flush),
      .rob_head    (rob_head),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .cdb_rob_idx (cdb_rob_idx),
      .cdb_grant   (cdb_grant)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic setSrc(input int i, input logic [5:0] tag, input logic [31:0] data,
                         input logic [3:0] rob);
      src_valid[i]          = 1'b1;
      src_tag[i*6 +: 6]     = tag;
      src_data[i*32 +: 32]  = data;
      src_rob_idx[i*4 +: 4] = rob;
   endtask

   // Holds the prepared inputs across one rising edge, then clears them.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      src_valid = '0;
      flush     = 1'b0;
   endtask

   task automatic expectBcast(input logic [5:0] tag, input logic [31:0] data,
                              input logic [3:0] rob, input logic [3:0] grant);
      exp_q.push_back({tag, data, rob, grant});
   endtask

   // Waits (bounded) for every expected broadcast, then idles a few cycles so
   // any stray broadcast reaches the monitor, and confirms the bus is idle.
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      checkOutput({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      checkOutput({name, "_idle_valid"}, 64'(cdb_valid), 64'd0);
   endtask

   // Monitor: every valid broadcast must match the head of the scoreboard;
   // an idle bus must show an all-zero grant.
   always @(negedge clk) begin
      if (!rst) begin
         if (cdb_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("[TB] FAIL unexpected_bcast: got grant %b tag %h data %h rob %h, expected no broadcast",
                        cdb_grant, cdb_tag, cdb_data, cdb_rob_idx);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("bcast", 64'({cdb_tag, cdb_data, cdb_rob_idx, cdb_grant}), 64'(mon_e));
            end
         end else begin
            checkOutput("idle_grant", 64'(cdb_grant), 64'd0);
         end
      end
   end

   initial begin
      rst         = 1'b1;
      flush       = 1'b0;
      src_valid   = '0;
      src_tag     = '0;
      src_data    = '0;
      src_rob_idx = '0;
      rob_head    = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outputs", 64'({cdb_valid, cdb_tag, cdb_data, cdb_rob_idx, cdb_grant}), 64'd0);
      checkOutput("reset_ready", 64'(src_ready), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", 64'(src_ready), 64'hF);

      // Single push from source 1, broadcast two edges later
      setSrc(1, 6'd5, 32'hDEADBEEF, 4'd3);
      expectBcast(6'd5, 32'hDEADBEEF, 4'd3, 4'b0010);
      applyStimulus();
      waitDrain("single");

`ifndef CDB_OLDEST_FIRST_EN
      // Reset mid-operation: queued pushes vanish and the pointer returns to 0
      setSrc(2, 6'd40, 32'hBAD0_0002, 4'd7);
      setSrc(3, 6'd41, 32'hBAD0_0003, 4'd8);
      applyStimulus();
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_outputs", 64'({cdb_valid, cdb_tag, cdb_data, cdb_rob_idx, cdb_grant}), 64'd0);
      checkOutput("midreset_ready", 64'(src_ready), 64'd0);
      rst = 1'b0;
      waitDrain("midreset");

      // All four sources at once from pointer 0: order 0,1,2,3
      for (int i = 0; i < 4; i++) begin
         setSrc(i, 6'(10 + i), 32'h1000_0000 + 32'(i), 4'(i));
         expectBcast(6'(10 + i), 32'h1000_0000 + 32'(i), 4'(i), 4'(1 << i));
      end
      applyStimulus();
      waitDrain("all4");

      // Back-pressure on source 2. Pointer is 0; grants follow
      // x0,y0,a,w0,x1,y1,b,w1,c as worked out by hand.
      expectBcast(6'd20, 32'h3000_0000, 4'd0, 4'b0001);
      expectBcast(6'd21, 32'h3000_0001, 4'd1, 4'b0010);
      expectBcast(6'd22, 32'h3000_000A, 4'd2, 4'b0100);
      expectBcast(6'd23, 32'h3000_0003, 4'd3, 4'b1000);
      expectBcast(6'd24, 32'h3000_0010, 4'd4, 4'b0001);
      expectBcast(6'd25, 32'h3000_0011, 4'd5, 4'b0010);
      expectBcast(6'd26, 32'h3000_000B, 4'd6, 4'b0100);
      expectBcast(6'd27, 32'h3000_0013, 4'd7, 4'b1000);
      expectBcast(6'd28, 32'h3000_000C, 4'd8, 4'b0100);
      setSrc(0, 6'd20, 32'h3000_0000, 4'd0);
      setSrc(1, 6'd21, 32'h3000_0001, 4'd1);
      setSrc(2, 6'd22, 32'h3000_000A, 4'd2);
      setSrc(3, 6'd23, 32'h3000_0003, 4'd3);
      applyStimulus();
      setSrc(0, 6'd24, 32'h3000_0010, 4'd4);
      setSrc(1, 6'd25, 32'h3000_0011, 4'd5);
      setSrc(2, 6'd26, 32'h3000_000B, 4'd6);
      setSrc(3, 6'd27, 32'h3000_0013, 4'd7);
      applyStimulus();
      checkOutput("full_ready", 64'(src_ready), 64'b0001);
      waited = 0;
      while (!src_ready[2] && waited < 10) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput("src2_ready_wait", 64'(waited), 64'd2);
      setSrc(2, 6'd28, 32'h3000_000C, 4'd8);
      applyStimulus();
      waitDrain("backpressure");

      // Sources 0 and 3 both kept busy, pointer is 3: grants 3,0,3,0
      expectBcast(6'd31, 32'h4000_0030, 4'd1, 4'b1000);
      expectBcast(6'd30, 32'h4000_0000, 4'd0, 4'b0001);
      expectBcast(6'd33, 32'h4000_0031, 4'd3, 4'b1000);
      expectBcast(6'd32, 32'h4000_0001, 4'd2, 4'b0001);
      setSrc(0, 6'd30, 32'h4000_0000, 4'd0);
      setSrc(3, 6'd31, 32'h4000_0030, 4'd1);
      applyStimulus();
      setSrc(0, 6'd32, 32'h4000_0001, 4'd2);
      setSrc(3, 6'd33, 32'h4000_0031, 4'd3);
      applyStimulus();
      waitDrain("alternate");

      // Flush with four queued entries and a simultaneous push: nothing from
      // either batch may ever appear on the bus.
      for (int i = 0; i < 4; i++) begin
         setSrc(i, 6'(50 + i), 32'hF1F1_0000 + 32'(i), 4'(i));
      end
      applyStimulus();
      for (int i = 0; i < 4; i++) begin
         setSrc(i, 6'(60 + i), 32'hF2F2_0000 + 32'(i), 4'(i + 4));
      end
      flush = 1'b1;
      applyStimulus();
      checkOutput("flush_valid", 64'(cdb_valid), 64'd0);
      checkOutput("flush_ready", 64'(src_ready), 64'hF);
      waitDrain("flush");

      // Pointer survives the flush (it was 1): source 1 wins before source 0
      expectBcast(6'd2, 32'h5000_0001, 4'd9, 4'b0010);
      expectBcast(6'd1, 32'h5000_0000, 4'd8, 4'b0001);
      setSrc(0, 6'd1, 32'h5000_0000, 4'd8);
      setSrc(1, 6'd2, 32'h5000_0001, 4'd9);
      applyStimulus();
      waitDrain("ptr_kept");
`else
      // Oldest-first: head 14, src0 rob 2 (age 4), src1 rob 15 (age 1)
      rob_head = 4'd14;
      expectBcast(6'd9, 32'h6000_0001, 4'd15, 4'b0010);
      expectBcast(6'd8, 32'h6000_0000, 4'd2, 4'b0001);
      setSrc(0, 6'd8, 32'h6000_0000, 4'd2);
      setSrc(1, 6'd9, 32'h6000_0001, 4'd15);
      applyStimulus();
      waitDrain("oldest");

      // Equal ages go to the lower source index
      expectBcast(6'd11, 32'h6000_0011, 4'd14, 4'b0010);
      expectBcast(6'd12, 32'h6000_0022, 4'd14, 4'b0100);
      setSrc(1, 6'd11, 32'h6000_0011, 4'd14);
      setSrc(2, 6'd12, 32'h6000_0022, 4'd14);
      applyStimulus();
      waitDrain("oldest_tie");
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
